// File: rtl/pic_pkg.sv
// Shared definitions for the picture stream reader.
//   DEF_ADDR_W / DEF_DATA_W / DEF_PIX_W : default word address, word and pixel widths
//   state_t                             : stream reader FSM state encoding
package pic_pkg;

  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 48;
  localparam int DEF_PIX_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/pic_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, registered
// read with one cycle of latency. A read and a write to the same address in
// the same cycle return the old contents.
//   clk     : clock
//   wr_en   : write strobe (commits on the rising edge)
//   wr_addr : write word address
//   wr_data : write word
//   rd_en   : read strobe, rd_data updates on the following edge
//   rd_addr : read word address
//   rd_data : registered read word
module pic_ram #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Both accesses are non-blocking, so a colliding read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pic_stream_reader.sv
// Streams a run of memory words out as a sequence of pixels, LSB pixel first.
// The host fills the internal word memory through an independent write port;
// a start request reads word_count words from base_addr upward (address wraps)
// and presents each word as NPIX pixels on a valid/ready interface.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/addr/data   : host write port into the word memory
//   start             : begin a stream (ignored while busy)
//   base_addr         : first word address of the stream
//   word_count        : number of words in the stream (0 gives an empty stream)
//   pix_data/valid    : pixel output, pix_last flags the final pixel
//   pix_ready         : consumer accept
//   busy              : stream in progress
//   done              : one-cycle pulse once the stream has finished
module pic_stream_reader
  import pic_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

  localparam int NPIX  = DATA_W / PIX_W;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W:0]     remain_reg;   // words left, including the one in flight
  logic [IDX_W-1:0]    idx_reg;
  logic [DATA_W-1:0]   word_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [DATA_W-1:0]   rd_data;
  logic                rd_en;
  logic [PIX_W-1:0]    lane [NPIX];
  logic                last_pix;
  logic                handshake;

  // A write coinciding with reset must not commit.
  pic_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en & ~rst),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr_reg),
    .rd_data (rd_data)
  );

  // Split the unpack register into pixel lanes, lane 0 in the LSBs.
  for (genvar gi = 0; gi < NPIX; gi++) begin : g_lane
    assign lane[gi] = word_reg[gi*PIX_W +: PIX_W];
  end

  assign rd_en     = (state_reg == ST_FETCH);
  assign last_pix  = (idx_reg == IDX_W'(NPIX - 1));
  assign pix_valid = (state_reg == ST_EMIT);
  assign pix_data  = lane[idx_reg];
  assign pix_last  = pix_valid && last_pix && (remain_reg == (ADDR_W+1)'(1));
  assign handshake = pix_valid && pix_ready;
  assign busy      = busy_reg;
  assign done      = done_reg;

  // busy and done are registered, so busy clears and done pulses on the edge
  // that leaves DONE; an empty stream therefore shows busy for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      remain_reg <= '0;
      idx_reg    <= '0;
      word_reg   <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_reg   <= base_addr;
            remain_reg <= word_count;
            busy_reg   <= 1'b1;
            state_reg  <= (word_count == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: state_reg <= ST_WAIT;
        ST_WAIT: begin
          word_reg  <= rd_data;
          idx_reg   <= '0;
          state_reg <= ST_EMIT;
        end
        ST_EMIT: begin
          if (handshake) begin
            if (!last_pix) begin
              idx_reg <= idx_reg + IDX_W'(1);
            end else if (remain_reg > (ADDR_W+1)'(1)) begin
              // Natural overflow of addr_reg gives the modulo wrap.
              addr_reg   <= addr_reg + ADDR_W'(1);
              remain_reg <= remain_reg - (ADDR_W+1)'(1);
              state_reg  <= ST_FETCH;
            end else begin
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_stream_reader.sv
// Scoreboard bench for pic_stream_reader: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every pixel handshake.
module tb_pic_stream_reader;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 48;
  localparam int PIX_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic              pix_last;
  logic              busy;
  logic              done;

  pic_stream_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PIX_W  (PIX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [8:0] exp_q [$];   // {last, pixel}

  bit         stall_mode = 1'b0;
  logic [3:0] pat = 4'b1001;   // ready sequence 1,0,0,1 (bit 0 first)
  int         pat_i = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w, input bit last_word);
    for (int k = 0; k < DATA_W / PIX_W; k++) begin
      exp_q.push_back({last_word && (k == DATA_W / PIX_W - 1), w[k*PIX_W +: PIX_W]});
    end
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_stream(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    start = 1'b1; base_addr = b; word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int done_before);
    int n = 0;
    while (done_cnt == done_before && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_done_in_time"}, 64'(n < 400), 64'd1);
    repeat (3) tick();
    chk({name, "_done_pulses"}, 64'(done_cnt - done_before), 64'd1);
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_cnt < target && n < 400) begin
      tick();
      n++;
    end
    chk("hs_reached", 64'(n < 400), 64'd1);
  endtask

  // Consumer ready pattern for the stall test.
  always @(posedge clk) begin
    #1;
    if (stall_mode) begin
      pix_ready = pat[pat_i];
      pat_i = (pat_i + 1) % 4;
    end
  end

  // Monitor: compares every handshake against the scoreboard and checks that
  // a stalled pixel stays put.
  logic             prev_stall = 1'b0;
  logic [PIX_W-1:0] prev_data;
  logic             prev_last;

  always @(negedge clk) begin
    logic [8:0] e;
    if (prev_stall) begin
      chk("stall_hold", {pix_valid, pix_last, pix_data}, {1'b1, prev_last, prev_data});
    end
    if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pixel: got %0h expected none", pix_data);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", {pix_last, pix_data}, e);
      end
    end
    prev_stall = (pix_valid === 1'b1) && (pix_ready !== 1'b1);
    prev_data  = pix_data;
    prev_last  = pix_last;
    if (done === 1'b1) done_cnt++;
  end

  localparam logic [DATA_W-1:0] W0 = 48'h060504030201;
  localparam logic [DATA_W-1:0] W1 = 48'h0C0B0A090807;
  localparam logic [DATA_W-1:0] WA = 48'hAAAAAAAAAAAA;
  localparam logic [DATA_W-1:0] W5 = 48'h555555555555;
  localparam logic [DATA_W-1:0] WN = 48'h1C1B1A191817;

  initial begin
    int d0;
    int h0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_pix_last", 64'(pix_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pix_data", 64'(pix_data), 64'd0);

    // Basic two-word stream, consumer always ready
    host_write(19'd0, W0);
    host_write(19'd1, W1);
    pix_ready = 1'b1;
    push_word(W0, 1'b0);
    push_word(W1, 1'b1);
    d0 = done_cnt;
    h0 = hs_cnt;
    start_stream(19'd0, 20'd2);
    chk("basic_busy", 64'(busy), 64'd1);
    wait_done("basic", d0);
    chk("basic_hs", 64'(hs_cnt - h0), 64'd12);

    // Same stream with a stalling consumer
    push_word(W0, 1'b0);
    push_word(W1, 1'b1);
    d0 = done_cnt;
    h0 = hs_cnt;
    pat_i = 0;
    stall_mode = 1'b1;
    start_stream(19'd0, 20'd2);
    wait_done("stall", d0);
    stall_mode = 1'b0;
    pix_ready = 1'b1;
    tick();
    chk("stall_hs", 64'(hs_cnt - h0), 64'd12);

    // Reset during the third pixel, with a write and a start in the same cycle
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b0, 8'h03});
    h0 = hs_cnt;
    start_stream(19'd0, 20'd2);
    wait_hs(h0 + 2);
    d0 = done_cnt;
    rst = 1'b1; wr_en = 1'b1; wr_addr = 19'd1; wr_data = 48'hDEADBEEFDEAD;
    start = 1'b1; base_addr = 19'd0; word_count = 20'd1;
    tick();
    rst = 1'b0; wr_en = 1'b0; start = 1'b0;
    chk("abort_pix_valid", 64'(pix_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (4) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_hs", 64'(hs_cnt - h0), 64'd3);
    push_word(W0, 1'b0);
    push_word(W1, 1'b1);
    start_stream(19'd0, 20'd2);
    wait_done("restream", d0);

    // Empty stream
    h0 = hs_cnt;
    d0 = done_cnt;
    start_stream(19'd0, 20'd0);
    chk("empty_busy_c1", 64'(busy), 64'd1);
    chk("empty_done_c1", 64'(done), 64'd0);
    tick();
    chk("empty_busy_c2", 64'(busy), 64'd0);
    chk("empty_done_c2", 64'(done), 64'd1);
    tick();
    chk("empty_done_c3", 64'(done), 64'd0);
    repeat (3) tick();
    chk("empty_hs", 64'(hs_cnt - h0), 64'd0);
    chk("empty_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Address wrap from the top word to word 0
    host_write(19'h7FFFF, WA);
    host_write(19'd0, W5);
    push_word(WA, 1'b0);
    push_word(W5, 1'b1);
    d0 = done_cnt;
    start_stream(19'h7FFFF, 20'd2);
    wait_done("wrap", d0);

    // Ignored second start, host rewrite of word 1 while word 0 emits
    host_write(19'd0, W0);
    host_write(19'd1, W1);
    push_word(W0, 1'b0);
    push_word(WN, 1'b1);
    d0 = done_cnt;
    h0 = hs_cnt;
    start_stream(19'd0, 20'd2);
    start_stream(19'd5, 20'd1);
    wait_hs(h0 + 1);
    host_write(19'd1, WN);
    wait_done("midwrite", d0);
    repeat (10) tick();
    chk("midwrite_hs", 64'(hs_cnt - h0), 64'd12);
    chk("midwrite_done_pulses", 64'(done_cnt - d0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
